// File: rtl/jtag_scan_sequencer_if.sv
// Command/response bus between the debug command source and the JTAG scan sequencer.
// The master issues commands and sees one response pulse per command; the slave is the sequencer.
interface jtag_scan_sequencer_if #(
    parameter int MAX_LEN = 32,
    parameter int LW      = $clog2(MAX_LEN + 1)
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [LW-1:0]      cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic               busy;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/jtag_scan_sequencer.sv
// JTAG master: expands RESET/IR/DR/IDLE commands into per-edge TMS/TDI schedules and captures TDO.
// Completion 1+2*DIV*edges clk cycles after accept; cmd_ready low while a command runs, response never stalls.
module jtag_scan_sequencer #(
    parameter int MAX_LEN = 32,
    parameter int DIV     = 2,
    parameter int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  TRST_N,
    jtag_scan_sequencer_if.slave  bus,
    output logic                  TCK,
    output logic                  TMS,
    output logic                  TDI,
    input  logic                  TDO
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [1:0] OP_RESET = 2'b00, OP_IR = 2'b01, OP_DR = 2'b10, OP_IDLE = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_PREFIX, S_TLR, S_HEADER, S_SHIFT, S_TAIL, S_RUN, S_DONE} state_e;

    state_e             state_q, state_d, nxt_state;
    logic [LW-1:0]      cnt_q, cnt_d, nxt_cnt, len_q, len_d, len_clamped;
    logic [DW-1:0]      div_q, div_d;
    logic               tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d, in_rti_q, in_rti_d;
    logic [1:0]         op_q, op_d;
    logic [MAX_LEN-1:0] data_q, data_d, sr_q, sr_d, rsp_data_q, rsp_data_d, tdi_sel;
    logic               cmd_ready, advance;

    // Segment that follows the TLR->RTI prefix edge; an empty IDLE goes straight to completion.
    function automatic state_e post_prefix(input logic [1:0] op, input logic [LW-1:0] len);
        if (op == OP_IDLE) return (len == '0) ? S_DONE : S_RUN;
        return S_HEADER;
    endfunction

    // Index of the last edge of each segment; zero-length scans stop the header at Capture.
    function automatic logic [LW-1:0] seg_last(input state_e st, input logic [1:0] op, input logic [LW-1:0] len);
        case (st)
            S_TLR:          return LW'(5);
            S_HEADER:       return LW'(((op == OP_IR) ? 2 : 1) + ((len != '0) ? 1 : 0));
            S_SHIFT, S_RUN: return len - LW'(1);
            S_TAIL:         return (len == '0) ? LW'(2) : LW'(1);
            default:        return '0;
        endcase
    endfunction

    function automatic logic tms_of(input state_e st, input logic [LW-1:0] cnt,
                                    input logic [1:0] op, input logic [LW-1:0] len);
        case (st)
            S_TLR:    return cnt != LW'(5);
            S_HEADER: return (cnt == '0) || ((op == OP_IR) && (cnt == LW'(1)));
            S_SHIFT:  return cnt == (len - LW'(1));
            S_TAIL:   return cnt < ((len == '0) ? LW'(2) : LW'(1));
            default:  return 1'b0;
        endcase
    endfunction

    assign len_clamped = (bus.cmd_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : bus.cmd_len;
    assign cmd_ready   = (state_q == S_IDLE) || (state_q == S_DONE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        tck_d      = tck_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;
        op_d       = op_q;
        len_d      = len_q;
        data_d     = data_q;
        sr_d       = sr_q;
        rsp_data_d = rsp_data_q;
        in_rti_d   = in_rti_q;
        advance    = 1'b0;
        nxt_state  = state_q;
        nxt_cnt    = cnt_q;
        tdi_sel    = '0;

        if (cmd_ready) begin
            state_d = S_IDLE;
            if (bus.cmd_valid) begin
                op_d    = bus.cmd_op;
                len_d   = len_clamped;
                data_d  = bus.cmd_data;
                sr_d    = '0;
                advance = 1'b1;
                nxt_cnt = '0;
                if (bus.cmd_op == OP_RESET)  nxt_state = S_TLR;
                else if (!in_rti_q)          nxt_state = S_PREFIX;
                else                         nxt_state = post_prefix(bus.cmd_op, len_clamped);
            end
        end else if (div_q == DW'(DIV - 1)) begin
            div_d = '0;
            tck_d = !tck_q;
            if (!tck_q) begin
                if (state_q == S_SHIFT) sr_d = {TDO, sr_q[MAX_LEN-1:1]};
            end else begin
                // Falling TCK: present the next edge's TMS/TDI so setup and hold are both DIV cycles.
                advance = 1'b1;
                if (cnt_q != seg_last(state_q, op_q, len_q)) begin
                    nxt_cnt = cnt_q + LW'(1);
                end else begin
                    nxt_cnt = '0;
                    case (state_q)
                        S_PREFIX: begin in_rti_d = 1'b1; nxt_state = post_prefix(op_q, len_q); end
                        S_HEADER: nxt_state = (len_q != '0) ? S_SHIFT : S_TAIL;
                        S_SHIFT:  nxt_state = S_TAIL;
                        S_TLR:    begin in_rti_d = 1'b1; nxt_state = S_DONE; end
                        default:  nxt_state = S_DONE;
                    endcase
                end
            end
        end else begin
            div_d = div_q + DW'(1);
        end

        if (advance) begin
            state_d = nxt_state;
            cnt_d   = nxt_cnt;
            div_d   = '0;
            if (nxt_state == S_DONE) begin
                tdi_d      = 1'b0;
                rsp_data_d = ((op_d == OP_IR) || (op_d == OP_DR)) ? (sr_d >> (MAX_LEN - int'(len_d))) : '0;
            end else begin
                tdi_sel = data_d >> nxt_cnt;
                tms_d   = tms_of(nxt_state, nxt_cnt, op_d, len_d);
                tdi_d   = (nxt_state == S_SHIFT) ? tdi_sel[0] : 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge TRST_N) begin
        if (!TRST_N) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
            op_q       <= OP_RESET;
            len_q      <= '0;
            data_q     <= '0;
            sr_q       <= '0;
            rsp_data_q <= '0;
            in_rti_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            tck_q      <= tck_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
            op_q       <= op_d;
            len_q      <= len_d;
            data_q     <= data_d;
            sr_q       <= sr_d;
            rsp_data_q <= rsp_data_d;
            in_rti_q   <= in_rti_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.busy      = !cmd_ready;
    assign bus.rsp_valid = (state_q == S_DONE);
    assign bus.rsp_data  = rsp_data_q;
    assign TCK           = tck_q;
    assign TMS           = tms_q;
    assign TDI           = tdi_q;
endmodule
